// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, ALU-op codes,
// FSM state encoding and datapath mux-select codes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam logic [2:0] ALU_NONE    = 3'b000;
    localparam logic [2:0] ALU_ORI     = 3'b001;
    localparam logic [2:0] ALU_LUI     = 3'b010;
    localparam logic [2:0] ALU_ANDI    = 3'b011;
    localparam logic [2:0] ALU_ADD     = 3'b100;
    localparam logic [2:0] ALU_MEMADDR = 3'b101;
    localparam logic [2:0] ALU_SUB     = 3'b110;
    localparam logic [2:0] ALU_RTYPE   = 3'b111;

    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    localparam logic [1:0] MEM_TO_REG_ALUOUT = 2'b00;
    localparam logic [1:0] MEM_TO_REG_MDR    = 2'b01;
    localparam logic [1:0] MEM_TO_REG_PC     = 2'b10;

    localparam logic [1:0] ALU_B_RT      = 2'b00;
    localparam logic [1:0] ALU_B_FOUR    = 2'b01;
    localparam logic [1:0] ALU_B_IMM     = 2'b10;
    localparam logic [1:0] ALU_B_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_INIT     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_ALU_WB   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WB   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_MEM,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ILLEGAL
    } op_class_t;

    // Groups opcodes by the execution path they take after DECODE.
    function automatic op_class_t classify(input logic [5:0] op);
        case (op)
            OP_RTYPE:                         return CLS_R;
            OP_ADDI, OP_ORI, OP_LUI, OP_ANDI: return CLS_I;
            OP_LW, OP_SW:                     return CLS_MEM;
            OP_BEQ, OP_BNE:                   return CLS_BRANCH;
            OP_J, OP_JAL:                     return CLS_JUMP;
            default:                          return CLS_ILLEGAL;
        endcase
    endfunction

    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ORI:  return ALU_ORI;
            OP_LUI:  return ALU_LUI;
            OP_ANDI: return ALU_ANDI;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_output_decoder.sv
// Combinational control-word decoder: maps the current FSM state, the latched
// opcode and the memory-ready flag onto the datapath control signals.
module ctrl_output_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_OP_WIDTH = 3
) (
    input  state_t                  state,
    input  logic [5:0]              opcode_q,
    input  logic                    rdy,
    output logic                    pc_write_o,
    output logic                    branch_eq_o,
    output logic                    branch_ne_o,
    output logic                    i_or_d_o,
    output logic                    mem_read_o,
    output logic                    mem_write_o,
    output logic                    ir_write_o,
    output logic [1:0]              reg_dst_o,
    output logic [1:0]              mem_to_reg_o,
    output logic                    reg_write_o,
    output logic                    alu_src_a_o,
    output logic [1:0]              alu_src_b_o,
    output logic [ALU_OP_WIDTH-1:0] alu_op_o,
    output logic [1:0]              pc_source_o
);

    logic [2:0] alu_code;

    // Every signal defaults to 0 so each state lists only what it asserts.
    always_comb begin
        pc_write_o   = 1'b0;
        branch_eq_o  = 1'b0;
        branch_ne_o  = 1'b0;
        i_or_d_o     = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_dst_o    = REG_DST_RT;
        mem_to_reg_o = MEM_TO_REG_ALUOUT;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = ALU_B_RT;
        alu_code     = ALU_NONE;
        pc_source_o  = PC_SRC_ALU;

        case (state)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = ALU_B_FOUR;
                alu_code    = ALU_ADD;
                ir_write_o  = rdy;
                pc_write_o  = rdy;
            end
            S_DECODE: begin
                alu_src_b_o = ALU_B_IMM_SH2;
                alu_code    = ALU_ADD;
            end
            S_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = ALU_B_RT;
                alu_code    = ALU_RTYPE;
            end
            S_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = ALU_B_IMM;
                alu_code    = imm_alu_op(opcode_q);
            end
            S_ALU_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = MEM_TO_REG_ALUOUT;
                reg_dst_o    = (opcode_q == OP_RTYPE) ? REG_DST_RD : REG_DST_RT;
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = ALU_B_IMM;
                alu_code    = ALU_MEMADDR;
            end
            S_MEM_RD: begin
                i_or_d_o   = 1'b1;
                mem_read_o = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = MEM_TO_REG_MDR;
                reg_dst_o    = REG_DST_RT;
            end
            S_MEM_WR: begin
                i_or_d_o    = 1'b1;
                mem_write_o = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = ALU_B_RT;
                alu_code    = ALU_SUB;
                pc_source_o = PC_SRC_ALUOUT;
                branch_eq_o = (opcode_q == OP_BEQ);
                branch_ne_o = (opcode_q == OP_BNE);
            end
            S_JUMP: begin
                pc_write_o  = 1'b1;
                pc_source_o = PC_SRC_JUMP;
                if (opcode_q == OP_JAL) begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = REG_DST_RA;
                    mem_to_reg_o = MEM_TO_REG_PC;
                end
            end
            default: begin
            end
        endcase
    end

    assign alu_op_o = ALU_OP_WIDTH'(alu_code);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: holds the FSM state, the latched opcode and the
// retired-instruction counter; control outputs come from ctrl_output_decoder.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_OP_WIDTH  = 3,
    parameter int CNT_WIDTH     = 32,
    parameter int USE_MEM_READY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5:0]              opcode_i,
    input  logic                    mem_ready_i,
    output logic                    pc_write_o,
    output logic                    branch_eq_o,
    output logic                    branch_ne_o,
    output logic                    i_or_d_o,
    output logic                    mem_read_o,
    output logic                    mem_write_o,
    output logic                    ir_write_o,
    output logic [1:0]              reg_dst_o,
    output logic [1:0]              mem_to_reg_o,
    output logic                    reg_write_o,
    output logic                    alu_src_a_o,
    output logic [1:0]              alu_src_b_o,
    output logic [ALU_OP_WIDTH-1:0] alu_op_o,
    output logic [1:0]              pc_source_o,
    output logic                    illegal_opcode_o,
    output logic [CNT_WIDTH-1:0]    instr_retired_o,
    output logic [3:0]              state_o
);

    state_t     state;
    state_t     next_state;
    logic [5:0] opcode_q;
    logic       rdy;
    logic       retire;

    assign rdy = (USE_MEM_READY != 0) ? mem_ready_i : 1'b1;

    // Next-state logic; unreachable encodings fall back to INIT.
    always_comb begin
        next_state = S_INIT;
        case (state)
            S_INIT:   next_state = S_FETCH;
            S_FETCH:  next_state = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (classify(opcode_i))
                    CLS_R:      next_state = S_EXEC_R;
                    CLS_I:      next_state = S_EXEC_I;
                    CLS_MEM:    next_state = S_MEM_ADDR;
                    CLS_BRANCH: next_state = S_BRANCH;
                    CLS_JUMP:   next_state = S_JUMP;
                    default:    next_state = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I:                       next_state = S_ALU_WB;
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP:     next_state = S_FETCH;
            S_MEM_ADDR: next_state = (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   next_state = rdy ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   next_state = rdy ? S_FETCH : S_MEM_WR;
            default:    next_state = S_INIT;
        endcase
    end

    // An instruction retires on the clock that leaves its final state.
    assign retire = (state == S_ALU_WB) || (state == S_MEM_WB) ||
                    (state == S_BRANCH) || (state == S_JUMP)   ||
                    ((state == S_MEM_WR) && rdy);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_INIT;
            opcode_q        <= 6'h00;
            instr_retired_o <= '0;
        end else begin
            state <= next_state;
            if (state == S_DECODE)
                opcode_q <= opcode_i;
            if (retire)
                instr_retired_o <= instr_retired_o + CNT_WIDTH'(1);
        end
    end

    assign illegal_opcode_o = (state == S_DECODE) && (classify(opcode_i) == CLS_ILLEGAL);
    assign state_o          = state;

    ctrl_output_decoder #(
        .ALU_OP_WIDTH (ALU_OP_WIDTH)
    ) u_decoder (
        .state        (state),
        .opcode_q     (opcode_q),
        .rdy          (rdy),
        .pc_write_o   (pc_write_o),
        .branch_eq_o  (branch_eq_o),
        .branch_ne_o  (branch_ne_o),
        .i_or_d_o     (i_or_d_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .ir_write_o   (ir_write_o),
        .reg_dst_o    (reg_dst_o),
        .mem_to_reg_o (mem_to_reg_o),
        .reg_write_o  (reg_write_o),
        .alu_src_a_o  (alu_src_a_o),
        .alu_src_b_o  (alu_src_b_o),
        .alu_op_o     (alu_op_o),
        .pc_source_o  (pc_source_o)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control (4-bit counter so the
// wrap can be reached), plus hand-written sequences for the wrap and a reset mid-wait.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode_i = 6'h00;
    logic       mem_ready_i = 1'b1;

    logic       pc_write_o, branch_eq_o, branch_ne_o, i_or_d_o;
    logic       mem_read_o, mem_write_o, ir_write_o, reg_write_o, alu_src_a_o;
    logic [1:0] reg_dst_o, mem_to_reg_o, alu_src_b_o, pc_source_o;
    logic [2:0] alu_op_o;
    logic       illegal_opcode_o;
    logic [3:0] instr_retired_o;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    multicycle_control #(
        .ALU_OP_WIDTH  (3),
        .CNT_WIDTH     (4),
        .USE_MEM_READY (1)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .opcode_i         (opcode_i),
        .mem_ready_i      (mem_ready_i),
        .pc_write_o       (pc_write_o),
        .branch_eq_o      (branch_eq_o),
        .branch_ne_o      (branch_ne_o),
        .i_or_d_o         (i_or_d_o),
        .mem_read_o       (mem_read_o),
        .mem_write_o      (mem_write_o),
        .ir_write_o       (ir_write_o),
        .reg_dst_o        (reg_dst_o),
        .mem_to_reg_o     (mem_to_reg_o),
        .reg_write_o      (reg_write_o),
        .alu_src_a_o      (alu_src_a_o),
        .alu_src_b_o      (alu_src_b_o),
        .alu_op_o         (alu_op_o),
        .pc_source_o      (pc_source_o),
        .illegal_opcode_o (illegal_opcode_o),
        .instr_retired_o  (instr_retired_o),
        .state_o          (state_o)
    );

    typedef struct packed {
        logic       pc_write;
        logic       branch_eq;
        logic       branch_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic [5:0] opcode;
        logic       ready;
        logic [3:0] exp_state;
        ctrl_t      exp_ctrl;
        logic [3:0] exp_cnt;
    } vec_t;

    // Hand-derived control words for each state.
    localparam ctrl_t C_ZERO       = '{default: '0};
    localparam ctrl_t C_FETCH_RDY  = '{pc_write: 1'b1, ir_write: 1'b1, mem_read: 1'b1,
                                       alu_src_b: 2'b01, alu_op: 3'b100, default: '0};
    localparam ctrl_t C_FETCH_WAIT = '{mem_read: 1'b1, alu_src_b: 2'b01, alu_op: 3'b100, default: '0};
    localparam ctrl_t C_DECODE     = '{alu_src_b: 2'b11, alu_op: 3'b100, default: '0};
    localparam ctrl_t C_DECODE_ILL = '{alu_src_b: 2'b11, alu_op: 3'b100, illegal: 1'b1, default: '0};
    localparam ctrl_t C_EXEC_R     = '{alu_src_a: 1'b1, alu_src_b: 2'b00, alu_op: 3'b111, default: '0};
    localparam ctrl_t C_EXEC_ADD   = '{alu_src_a: 1'b1, alu_src_b: 2'b10, alu_op: 3'b100, default: '0};
    localparam ctrl_t C_EXEC_ORI   = '{alu_src_a: 1'b1, alu_src_b: 2'b10, alu_op: 3'b001, default: '0};
    localparam ctrl_t C_EXEC_LUI   = '{alu_src_a: 1'b1, alu_src_b: 2'b10, alu_op: 3'b010, default: '0};
    localparam ctrl_t C_EXEC_ANDI  = '{alu_src_a: 1'b1, alu_src_b: 2'b10, alu_op: 3'b011, default: '0};
    localparam ctrl_t C_ALUWB_R    = '{reg_write: 1'b1, reg_dst: 2'b01, default: '0};
    localparam ctrl_t C_ALUWB_I    = '{reg_write: 1'b1, default: '0};
    localparam ctrl_t C_MEM_ADDR   = '{alu_src_a: 1'b1, alu_src_b: 2'b10, alu_op: 3'b101, default: '0};
    localparam ctrl_t C_MEM_RD     = '{i_or_d: 1'b1, mem_read: 1'b1, default: '0};
    localparam ctrl_t C_MEM_WB     = '{reg_write: 1'b1, mem_to_reg: 2'b01, default: '0};
    localparam ctrl_t C_MEM_WR     = '{i_or_d: 1'b1, mem_write: 1'b1, default: '0};
    localparam ctrl_t C_BEQ        = '{alu_src_a: 1'b1, alu_op: 3'b110, pc_source: 2'b01,
                                       branch_eq: 1'b1, default: '0};
    localparam ctrl_t C_BNE        = '{alu_src_a: 1'b1, alu_op: 3'b110, pc_source: 2'b01,
                                       branch_ne: 1'b1, default: '0};
    localparam ctrl_t C_J          = '{pc_write: 1'b1, pc_source: 2'b10, default: '0};
    localparam ctrl_t C_JAL        = '{pc_write: 1'b1, pc_source: 2'b10, reg_write: 1'b1,
                                       reg_dst: 2'b10, mem_to_reg: 2'b10, default: '0};

    ctrl_t act;
    assign act = {pc_write_o, branch_eq_o, branch_ne_o, i_or_d_o, mem_read_o, mem_write_o,
                  ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o,
                  alu_op_o, pc_source_o, illegal_opcode_o};

    vec_t vecs[$];
    int   vectors_applied = 0;
    int   miscompares = 0;

    function automatic void add(input logic [5:0] op, input logic rdy, input state_t st,
                                input ctrl_t c, input logic [3:0] cnt);
        vecs.push_back('{op, rdy, 4'(st), c, cnt});
    endfunction

    task automatic check_output(input int idx, input logic [3:0] es, input ctrl_t ec,
                                input logic [3:0] ecnt);
        vectors_applied++;
        if (state_o !== es || act !== ec || instr_retired_o !== ecnt) begin
            miscompares++;
            $display("[TB] FAIL vec %0d: state %0d (required %0d), ctrl %h (required %h), retired %0d (required %0d)",
                     idx, state_o, es, act, ec, instr_retired_o, ecnt);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge, outputs sampled 2 units later.
    task automatic apply_stimulus(input int idx, input vec_t v);
        opcode_i    = v.opcode;
        mem_ready_i = v.ready;
        #2;
        check_output(idx, v.exp_state, v.exp_ctrl, v.exp_cnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int idx;

        // add
        add(6'h00, 1'b1, S_INIT,   C_ZERO,      4'd0);
        add(6'h00, 1'b1, S_FETCH,  C_FETCH_RDY, 4'd0);
        add(6'h00, 1'b1, S_DECODE, C_DECODE,    4'd0);
        add(6'h00, 1'b1, S_EXEC_R, C_EXEC_R,    4'd0);
        add(6'h00, 1'b1, S_ALU_WB, C_ALUWB_R,   4'd0);
        // addi, ori, lui, andi
        add(6'h08, 1'b1, S_FETCH,  C_FETCH_RDY, 4'd1);
        add(6'h08, 1'b1, S_DECODE, C_DECODE,    4'd1);
        add(6'h08, 1'b1, S_EXEC_I, C_EXEC_ADD,  4'd1);
        add(6'h08, 1'b1, S_ALU_WB, C_ALUWB_I,   4'd1);
        add(6'h0D, 1'b1, S_FETCH,  C_FETCH_RDY, 4'd2);
        add(6'h0D, 1'b1, S_DECODE, C_DECODE,    4'd2);
        add(6'h0D, 1'b1, S_EXEC_I, C_EXEC_ORI,  4'd2);
        add(6'h0D, 1'b1, S_ALU_WB, C_ALUWB_I,   4'd2);
        add(6'h0F, 1'b1, S_FETCH,  C_FETCH_RDY, 4'd3);
        add(6'h0F, 1'b1, S_DECODE, C_DECODE,    4'd3);
        add(6'h0F, 1'b1, S_EXEC_I, C_EXEC_LUI,  4'd3);
        add(6'h0F, 1'b1, S_ALU_WB, C_ALUWB_I,   4'd3);
        add(6'h0C, 1'b1, S_FETCH,  C_FETCH_RDY, 4'd4);
        add(6'h0C, 1'b1, S_DECODE, C_DECODE,    4'd4);
        add(6'h0C, 1'b1, S_EXEC_I, C_EXEC_ANDI, 4'd4);
        add(6'h0C, 1'b1, S_ALU_WB, C_ALUWB_I,   4'd4);
        // lw with three wait cycles in MEM_RD
        add(6'h23, 1'b1, S_FETCH,    C_FETCH_RDY, 4'd5);
        add(6'h23, 1'b1, S_DECODE,   C_DECODE,    4'd5);
        add(6'h23, 1'b1, S_MEM_ADDR, C_MEM_ADDR,  4'd5);
        add(6'h23, 1'b0, S_MEM_RD,   C_MEM_RD,    4'd5);
        add(6'h23, 1'b0, S_MEM_RD,   C_MEM_RD,    4'd5);
        add(6'h23, 1'b0, S_MEM_RD,   C_MEM_RD,    4'd5);
        add(6'h23, 1'b1, S_MEM_RD,   C_MEM_RD,    4'd5);
        add(6'h23, 1'b1, S_MEM_WB,   C_MEM_WB,    4'd5);
        // sw with one wait in FETCH and one in MEM_WR
        add(6'h2B, 1'b0, S_FETCH,    C_FETCH_WAIT, 4'd6);
        add(6'h2B, 1'b1, S_FETCH,    C_FETCH_RDY,  4'd6);
        add(6'h2B, 1'b1, S_DECODE,   C_DECODE,     4'd6);
        add(6'h2B, 1'b1, S_MEM_ADDR, C_MEM_ADDR,   4'd6);
        add(6'h2B, 1'b0, S_MEM_WR,   C_MEM_WR,     4'd6);
        add(6'h2B, 1'b1, S_MEM_WR,   C_MEM_WR,     4'd6);
        // beq, bne, j, jal
        add(6'h04, 1'b1, S_FETCH,  C_FETCH_RDY, 4'd7);
        add(6'h04, 1'b1, S_DECODE, C_DECODE,    4'd7);
        add(6'h04, 1'b1, S_BRANCH, C_BEQ,       4'd7);
        add(6'h05, 1'b1, S_FETCH,  C_FETCH_RDY, 4'd8);
        add(6'h05, 1'b1, S_DECODE, C_DECODE,    4'd8);
        add(6'h05, 1'b1, S_BRANCH, C_BNE,       4'd8);
        add(6'h02, 1'b1, S_FETCH,  C_FETCH_RDY, 4'd9);
        add(6'h02, 1'b1, S_DECODE, C_DECODE,    4'd9);
        add(6'h02, 1'b1, S_JUMP,   C_J,         4'd9);
        add(6'h03, 1'b1, S_FETCH,  C_FETCH_RDY, 4'd10);
        add(6'h03, 1'b1, S_DECODE, C_DECODE,    4'd10);
        add(6'h03, 1'b1, S_JUMP,   C_JAL,       4'd10);
        // illegal opcode: flagged in DECODE, back to FETCH, not counted
        add(6'h3F, 1'b1, S_FETCH,  C_FETCH_RDY,  4'd11);
        add(6'h3F, 1'b1, S_DECODE, C_DECODE_ILL, 4'd11);

        // Reset state, checked while reset is still asserted.
        reset = 1'b1;
        #3;
        check_output(-1, 4'(S_INIT), C_ZERO, 4'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            apply_stimulus(i, vecs[i]);
        idx = vecs.size();

        // Five more beq retirements take the 4-bit counter from 11 through 15 to 0.
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(idx++, '{6'h04, 1'b1, 4'(S_FETCH),  C_FETCH_RDY, 4'(11 + k)});
            apply_stimulus(idx++, '{6'h04, 1'b1, 4'(S_DECODE), C_DECODE,    4'(11 + k)});
            apply_stimulus(idx++, '{6'h04, 1'b1, 4'(S_BRANCH), C_BEQ,       4'(11 + k)});
        end
        apply_stimulus(idx++, '{6'h00, 1'b1, 4'(S_FETCH),  C_FETCH_RDY, 4'd0});
        apply_stimulus(idx++, '{6'h00, 1'b1, 4'(S_DECODE), C_DECODE,    4'd0});
        apply_stimulus(idx++, '{6'h00, 1'b1, 4'(S_EXEC_R), C_EXEC_R,    4'd0});
        apply_stimulus(idx++, '{6'h00, 1'b1, 4'(S_ALU_WB), C_ALUWB_R,   4'd0});

        // sw stalled in MEM_WR, then reset asserted mid-wait.
        apply_stimulus(idx++, '{6'h2B, 1'b1, 4'(S_FETCH),    C_FETCH_RDY, 4'd1});
        apply_stimulus(idx++, '{6'h2B, 1'b1, 4'(S_DECODE),   C_DECODE,    4'd1});
        apply_stimulus(idx++, '{6'h2B, 1'b1, 4'(S_MEM_ADDR), C_MEM_ADDR,  4'd1});
        apply_stimulus(idx++, '{6'h2B, 1'b0, 4'(S_MEM_WR),   C_MEM_WR,    4'd1});
        opcode_i    = 6'h2B;
        mem_ready_i = 1'b0;
        #2;
        check_output(idx++, 4'(S_MEM_WR), C_MEM_WR, 4'd1);
        reset = 1'b1;
        #1;
        check_output(idx++, 4'(S_INIT), C_ZERO, 4'd0);
        @(posedge clk);
        #1;
        check_output(idx++, 4'(S_INIT), C_ZERO, 4'd0);
        reset = 1'b0;
        apply_stimulus(idx++, '{6'h00, 1'b1, 4'(S_INIT),  C_ZERO,      4'd0});
        apply_stimulus(idx++, '{6'h00, 1'b1, 4'(S_FETCH), C_FETCH_RDY, 4'd0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
